usart_tx_arbiter: RTL and testbench
===================================

# usart_tx_arbiter

Shares one `USART_Tx` instance between `NUM_REQ` byte producers. Grants one requester per UART frame, round-robin by default, and presents the byte plus a one-cycle `enable` strobe to the transmitter. Tracks frame duration internally so that no new byte is issued while a frame is still on the line. Sits between the application-side producers and the `USART_Tx` `_data`/`enable` inputs.

## Interface
- `CLK_FREQ`, 100000000, system clock frequency in Hz
- `BAUD_RATE`, 115200, line rate in baud
- `DATA_BIT`, 8, data bits per frame (5..8)
- `NUM_REQ`, 4, number of requesters (1..16)
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req`  in  NUM_REQ  per-requester request, held until `ack`
- `req_data`  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i]
- `ack`  out  NUM_REQ  one-cycle pulse: byte of requester i accepted
- `tx_data`  out  8  byte to `USART_Tx._data`, held until the next grant
- `tx_enable`  out  1  one-cycle start strobe to `USART_Tx.enable`
- `busy`  out  1  high while a frame is in flight
- `grant_id`  out  clog2(NUM_REQ) (min 1)  index of the last granted requester

## Operation
- Derived constants: `BIT_CYCLES = CLK_FREQ/BAUD_RATE` (integer division), `FRAME_CYCLES = BIT_CYCLES*(DATA_BIT+2)` (start + data + 1 stop).
- Frame counter width is clog2(FRAME_CYCLES+1).
- FSM states: IDLE and SEND.
- **IDLE, no `req` bit set:** stay in IDLE.
- **IDLE, any `req` bit set:** select winner w. On the same edge:
  - `tx_data <= req_data[w]`
  - `tx_enable <= 1`, `ack[w] <= 1`
  - `grant_id <= w`, `last <= w`
  - `cnt <= FRAME_CYCLES-1`
  - go to SEND
- **SEND:** `tx_enable` and `ack` return to 0. `cnt` decrements each cycle. When `cnt == 0`, go to IDLE.
- **Round-robin selection:** search `last+1, last+2, …` modulo NUM_REQ; the first set `req` bit wins.
- **Requester rules:**
  - A requester must hold `req` and `req_data` stable until its `ack`.
  - Dropping `req` before `ack` withdraws the request without error.
  - `req` sampled during SEND is ignored.
  - A requester that keeps `req` high after `ack` is treated as a new request.
- `busy` = (state == SEND).
- `NUM_REQ == 1`: the arbiter degenerates to a pacing gate; `grant_id` is a constant 0.

## Timing
- **Reset values:**
  - `ack = 0`, `tx_enable = 0`, `tx_data = 0`, `busy = 0`, `grant_id = 0`
  - state = IDLE, `cnt = 0`, `last = NUM_REQ-1` (so requester 0 wins first)
- **Latency:** `req` high at edge N while IDLE → `ack`/`tx_enable` high during cycle N+1 (registered, coincident, exactly one cycle).
- **Frame spacing:** `tx_enable` pulses are spaced at least FRAME_CYCLES+1 cycles apart. Under continuous demand they are spaced exactly FRAME_CYCLES+1 cycles apart (one IDLE cycle per frame).
- `tx_data` changes only on the grant edge.
- **Reset mid-frame:** asynchronous clear to the reset values. The granted byte is considered lost; the requester has already seen `ack` and does not retry.

## Configuration
- Macro `USART_TX_ARB_FIXED_PRIO_EN`.
- **Defined:** fixed priority; the lowest set index always wins. `last` is not used for selection but is still updated for `grant_id`.
- **Undefined:** round-robin as described in Operation.

## Structure
- Shared package `usart_pkg`:
  - function computing `BIT_CYCLES`/`FRAME_CYCLES` from CLK_FREQ, BAUD_RATE, DATA_BIT
  - FSM state encoding (IDLE, SEND)
- Sub-module `usart_rr_picker`: combinational rotating priority encoder.
  - Inputs: `req`, `last`
  - Outputs: `valid`, `winner`
  - Holds the macro-selected fixed-priority branch.

## Test plan
Bench settings: CLK_FREQ=1000000, BAUD_RATE=100000, DATA_BIT=8, NUM_REQ=4 (BIT_CYCLES=10, FRAME_CYCLES=100).
- **Single request:** `req=4'b0100`, byte `8'hA5` on slot 2 → one cycle later `tx_enable=1`, `ack=4'b0100`, `tx_data=8'hA5`, `grant_id=2`. `busy` stays high for 100 cycles.
- **All four requesting from reset**, bytes `8'h10`..`8'h13` → grants in order 0,1,2,3. `tx_enable` pulses 101 cycles apart, `tx_data` sequence `8'h10`, `8'h11`, `8'h12`, `8'h13`.
- **Fairness:** req0 held high continuously, req3 raised after the first grant → grants alternate 0,3,0,3. With `USART_TX_ARB_FIXED_PRIO_EN` defined, the grants are 0,0,0,0.
- **Request during SEND:** req1 raised in cycle 50 of frame → no `ack` until the frame ends, then `ack[1]` exactly 101 cycles after the previous `tx_enable`.
- **Withdrawal:** req2 raised and dropped within SEND → no `ack[2]`, no extra `tx_enable`.
- **Reset mid-frame:** `reset=0` at cycle 40 of SEND → `busy`, `tx_enable`, `ack`, `tx_data`, `grant_id` are 0 immediately (asynchronous). After release with `req=4'b1000`, grant goes to 3 one cycle later.

Source files
------------

// File: rtl/usart_pkg.sv
// Shared USART constants: baud/frame timing helpers and the tx arbiter state encoding.
package usart_pkg;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} arb_state_t;

  function automatic int bit_cycles(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // start bit + data bits + one stop bit
  function automatic int frame_cycles(input int clk_freq, input int baud_rate, input int data_bit);
    return bit_cycles(clk_freq, baud_rate) * (data_bit + 2);
  endfunction

endpackage

// File: rtl/usart_rr_picker.sv
// Combinational rotating priority encoder: first set req after `last`, wrapping.
// USART_TX_ARB_FIXED_PRIO_EN selects plain lowest-index-wins priority instead.
module usart_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic               valid,
  output logic [IW-1:0]      winner
);

  logic [IW-1:0] idx;

`ifdef USART_TX_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = IW'(i);
      if (req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end
`else
  // Scan from the farthest slot back to last+1 so the nearest candidate is written last.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % NUM_REQ);
      if (req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end
`endif

endmodule

// File: rtl/usart_tx_arbiter.sv
// Shares one USART_Tx between NUM_REQ byte producers, one grant per frame, frame-paced.
// Round-robin by default; USART_TX_ARB_FIXED_PRIO_EN switches to fixed priority.
module usart_tx_arbiter
  import usart_pkg::*;
#(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BIT  = 8,
  parameter int NUM_REQ   = 4,
  localparam int IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [7:0]           tx_data,
  output logic                 tx_enable,
  output logic                 busy,
  output logic [IW-1:0]        grant_id
);

  localparam int FRAME_CYCLES = frame_cycles(CLK_FREQ, BAUD_RATE, DATA_BIT);
  localparam int CW           = $clog2(FRAME_CYCLES + 1);

  arb_state_t                state;
  logic [CW-1:0]             cnt;
  logic [IW-1:0]             last;
  logic [IW-1:0]             winner;
  logic                      valid;
  logic [NUM_REQ-1:0][7:0]   bytes;

  assign bytes = req_data;
  assign busy  = (state == SEND);

  usart_rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req    (req),
    .last   (last),
    .valid  (valid),
    .winner (winner)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= IW'(NUM_REQ - 1);
      ack       <= '0;
      tx_enable <= 1'b0;
      tx_data   <= '0;
      grant_id  <= '0;
    end else begin
      ack       <= '0;
      tx_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            tx_data   <= bytes[winner];
            tx_enable <= 1'b1;
            ack       <= NUM_REQ'(1) << winner;
            grant_id  <= winner;
            last      <= winner;
            cnt       <= CW'(FRAME_CYCLES - 1);
            state     <= SEND;
          end
        end
        SEND: begin
          // Frame occupies FRAME_CYCLES cycles; the cnt==0 cycle hands back to IDLE.
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usart_tx_arbiter.sv
// Scoreboard bench for usart_tx_arbiter: cycle-level reference model plus decoupled monitor.
module tb_usart_tx_arbiter;

  localparam int CF = 1000000;
  localparam int BR = 100000;
  localparam int DB = 8;
  localparam int NR = 4;
  localparam int FC = (CF / BR) * (DB + 2);

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [NR-1:0]   ack;
  logic [7:0]      tx_data;
  logic            tx_enable;
  logic            busy;
  logic [1:0]      grant_id;

  always #5 clk = ~clk;

  usart_tx_arbiter #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BIT(DB), .NUM_REQ(NR)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .tx_data   (tx_data),
    .tx_enable (tx_enable),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  typedef struct {int id; logic [7:0] data; int edge_n;} exp_t;
  exp_t q[$];

  int total = 0;
  int bad   = 0;
  int e     = 0;
  int m_last = NR - 1;
  int free_edge = 0;
  int g_edge = 0;
  bit g_vld = 0;
  logic [NR-1:0] hold = '0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, want, $time);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] r, input int l);
`ifdef USART_TX_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NR; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= NR; k++) if (r[(l + k) % NR]) return (l + k) % NR;
`endif
    return -1;
  endfunction

  // Reference: the line is free again FC+1 edges after a grant edge.
  always @(posedge clk) begin
    int w;
    if (!reset) begin
      m_last = NR - 1; free_edge = 0; g_vld = 0;
    end else if (e >= free_edge && req != '0) begin
      w = pick(req, m_last);
      q.push_back('{w, req_data[8*w +: 8], e});
      m_last = w; free_edge = e + FC + 1; g_edge = e; g_vld = 1;
    end
    e++;
  end

  always @(negedge clk) begin
    exp_t x;
    if (reset) begin
      chk("busy", {31'd0, busy}, {31'd0, g_vld && (e - 1 - g_edge) < FC});
      if (tx_enable || ack != '0) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_grant ack=%b tx_enable=%b required none t=%0t", ack, tx_enable, $time);
        end else begin
          x = q.pop_front();
          chk("ack", {28'd0, ack}, 32'(1 << x.id));
          chk("tx_enable", {31'd0, tx_enable}, 32'd1);
          chk("tx_data", {24'd0, tx_data}, {24'd0, x.data});
          chk("grant_id", {30'd0, grant_id}, 32'(x.id));
          chk("grant_cycle", 32'(e), 32'(x.edge_n + 1));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NR; i++) if (ack[i] && !hold[i]) req[i] = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_ack(input int id);
    bit got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      if (ack[id]) got = 1;
    end
    if (!got) chk("wait_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0; hold = '0; reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"}, {28'd0, ack}, 32'd0);
    chk({tag, "_tx_enable"}, {31'd0, tx_enable}, 32'd0);
    chk({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_grant_id"}, {30'd0, grant_id}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // single request on slot 2
    tick();
    req_data[23:16] = 8'hA5; req[2] = 1'b1;
    run(120);

    // all four from reset: 0,1,2,3
    do_reset();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10}; req = 4'hF;
    run(4 * (FC + 1) + 10);

    // fairness: req0 and req3 held continuously
    do_reset();
    hold = 4'b1001; req_data[7:0] = 8'h20; req[0] = 1'b1;
    wait_ack(0);
    req_data[31:24] = 8'h23; req[3] = 1'b1;
    run(4 * (FC + 1));
    tick(); hold = '0; req = '0;
    run(FC + 10);

    // request raised mid-frame waits for the line
    req_data[7:0] = 8'h31; req[0] = 1'b1;
    wait_ack(0);
    run(49);
    req_data[15:8] = 8'h32; req[1] = 1'b1;
    run(FC + 20);

    // withdrawal during SEND
    req_data[7:0] = 8'h41; req[0] = 1'b1;
    wait_ack(0);
    run(20);
    req_data[23:16] = 8'h42; req[2] = 1'b1;
    run(20);
    req[2] = 1'b0;
    run(FC + 10);

    // random traffic with occasional withdrawals
    for (int c = 0; c < 2500; c++) begin
      tick();
      for (int i = 0; i < NR; i++) begin
        if (!req[i] && $urandom_range(0, 29) == 0) begin
          req_data[8*i +: 8] = 8'($urandom);
          req[i] = 1'b1;
        end else if (req[i] && !ack[i] && $urandom_range(0, 199) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    tick(); req = '0;
    run(FC + 10);

    // reset mid-frame, then slot 3 wins first
    req_data[15:8] = 8'h51; req[1] = 1'b1;
    wait_ack(1);
    run(39);
    #1 reset = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge clk);
    req = '0;
    @(negedge clk);
    reset = 1'b1;
    req_data[31:24] = 8'h5A; req[3] = 1'b1;
    run(FC + 10);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
